// File: rtl/decode_stage_pkg.sv
// Shared constants for the decode stage: widths, opcode encodings, field positions
// and immediate sign-extension helpers.
package decode_stage_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_NOP  = 4'hF;

    localparam int OP_LSB = 12;
    localparam int RD_LSB = 8;
    localparam int RS_LSB = 4;
    localparam int RT_LSB = 0;

    function automatic logic [DATA_W-1:0] sext4(input logic [3:0] v);
        return {{(DATA_W-4){v[3]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
        return {{(DATA_W-8){v[7]}}, v};
    endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// 16x16 register file with two async read ports and one sync write port;
// r0 is hardwired to zero and a same-cycle write is forwarded to the readers.
module register_file
    import decode_stage_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = REG_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_raddr_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [DW-1:0] o_rdata_a,
    output logic [DW-1:0] o_rdata_b,
    input  logic          i_wen,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata
);

    logic [DW-1:0] r_mem [1<<AW];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < (1<<AW); i++) r_mem[i] <= '0;
        end else if (i_wen && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Bypass lets writeback and decode of a dependent instruction share a cycle.
    always_comb begin
        o_rdata_a = r_mem[i_raddr_a];
        o_rdata_b = r_mem[i_raddr_b];
        if (i_wen && (i_waddr == i_raddr_a)) o_rdata_a = i_wdata;
        if (i_wen && (i_waddr == i_raddr_b)) o_rdata_b = i_wdata;
        if (i_raddr_a == '0) o_rdata_a = '0;
        if (i_raddr_b == '0) o_rdata_b = '0;
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: splits fields, reads operands, sign-extends immediates, detects
// load-use hazards, resolves JMP and produces the decode/execute latch.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instruction,
    input  logic [DATA_W-1:0] Next_PC,
    input  logic              instr_valid,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              jump_taken,
    output logic [DATA_W-1:0] jump_target,
    output logic              d_valid,
    output logic [3:0]        d_opcode,
    output logic [REG_AW-1:0] d_rd,
    output logic [DATA_W-1:0] d_rs_val,
    output logic [DATA_W-1:0] d_rt_val,
    output logic [DATA_W-1:0] d_imm,
    output logic [DATA_W-1:0] d_pc,
    output logic              d_reg_write,
    output logic              d_mem_read,
    output logic              d_mem_write,
    output logic              d_branch
);

    logic [3:0]        w_op;
    logic [REG_AW-1:0] w_rd, w_rs, w_rt;
    logic [REG_AW-1:0] w_addr_a, w_addr_b;
    logic              w_use_a, w_use_b;
    logic [DATA_W-1:0] w_val_a, w_val_b, w_imm;
    logic              w_reg_write, w_mem_read, w_mem_write, w_branch;
    logic              w_in_valid, w_hazard, w_jump, w_bubble;

    logic              r_squash;
    logic              r_valid, r_reg_write, r_mem_read, r_mem_write, r_branch;
    logic [3:0]        r_opcode;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_rs_val, r_rt_val, r_imm, r_pc;

    assign w_op = instruction[OP_LSB +: 4];
    assign w_rd = instruction[RD_LSB +: REG_AW];
    assign w_rs = instruction[RS_LSB +: REG_AW];
    assign w_rt = instruction[RT_LSB +: REG_AW];

    // SW and BEQ compare/store rd, so rd goes out on the second operand port.
    always_comb begin
        w_addr_a    = '0;
        w_addr_b    = '0;
        w_use_a     = 1'b0;
        w_use_b     = 1'b0;
        w_imm       = '0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        case (w_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                w_addr_a = w_rs; w_use_a = 1'b1;
                w_addr_b = w_rt; w_use_b = 1'b1;
                w_reg_write = 1'b1;
            end
            OP_ADDI: begin
                w_addr_a = w_rd; w_use_a = 1'b1;
                w_imm = sext8(instruction[7:0]);
                w_reg_write = 1'b1;
            end
            OP_LW: begin
                w_addr_a = w_rs; w_use_a = 1'b1;
                w_imm = sext4(w_rt);
                w_reg_write = 1'b1;
                w_mem_read = 1'b1;
            end
            OP_SW, OP_BEQ: begin
                w_addr_a = w_rs; w_use_a = 1'b1;
                w_addr_b = w_rd; w_use_b = 1'b1;
                w_imm = sext4(w_rt);
                w_mem_write = (w_op == OP_SW);
                w_branch = (w_op == OP_BEQ);
            end
            default: ;
        endcase
    end

    register_file u_regs (
        .clk       (clk),
        .rst       (rst),
        .i_raddr_a (w_addr_a),
        .i_raddr_b (w_addr_b),
        .o_rdata_a (w_val_a),
        .o_rdata_b (w_val_b),
        .i_wen     (wb_en),
        .i_waddr   (wb_addr),
        .i_wdata   (wb_data)
    );

    assign w_in_valid = instr_valid && !r_squash;
    assign w_hazard   = w_in_valid && r_valid && r_mem_read && (r_rd != '0) &&
                        ((w_use_a && (w_addr_a == r_rd)) || (w_use_b && (w_addr_b == r_rd)));
    assign w_jump     = w_in_valid && (w_op == OP_JMP) && !w_hazard && !flush;
    assign w_bubble   = flush || w_hazard || !w_in_valid || (w_op == OP_JMP);

    assign stall       = w_hazard && !flush;
    assign jump_taken  = w_jump;
    assign jump_target = {Next_PC[15:12], instruction[11:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_squash    <= 1'b0;
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_branch    <= 1'b0;
            r_opcode    <= '0;
            r_rd        <= '0;
            r_rs_val    <= '0;
            r_rt_val    <= '0;
            r_imm       <= '0;
            r_pc        <= '0;
        end else begin
            r_squash    <= w_jump;
            r_opcode    <= w_op;
            r_rd        <= w_rd;
            r_rs_val    <= w_val_a;
            r_rt_val    <= w_val_b;
            r_imm       <= w_imm;
            r_pc        <= Next_PC;
            r_valid     <= !w_bubble;
            r_reg_write <= !w_bubble && w_reg_write;
            r_mem_read  <= !w_bubble && w_mem_read;
            r_mem_write <= !w_bubble && w_mem_write;
            r_branch    <= !w_bubble && w_branch;
        end
    end

    assign d_valid     = r_valid;
    assign d_opcode    = r_opcode;
    assign d_rd        = r_rd;
    assign d_rs_val    = r_rs_val;
    assign d_rt_val    = r_rt_val;
    assign d_imm       = r_imm;
    assign d_pc        = r_pc;
    assign d_reg_write = r_reg_write;
    assign d_mem_read  = r_mem_read;
    assign d_mem_write = r_mem_write;
    assign d_branch    = r_branch;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage with hand-computed expectations.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instruction, Next_PC, wb_data;
    logic        instr_valid, flush, wb_en;
    logic [3:0]  wb_addr;
    logic        stall, jump_taken;
    logic [15:0] jump_target;
    logic        d_valid;
    logic [3:0]  d_opcode, d_rd;
    logic [15:0] d_rs_val, d_rt_val, d_imm, d_pc;
    logic        d_reg_write, d_mem_read, d_mem_write, d_branch;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .instruction(instruction), .Next_PC(Next_PC),
        .instr_valid(instr_valid), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .stall(stall), .jump_taken(jump_taken), .jump_target(jump_target),
        .d_valid(d_valid), .d_opcode(d_opcode), .d_rd(d_rd), .d_rs_val(d_rs_val),
        .d_rt_val(d_rt_val), .d_imm(d_imm), .d_pc(d_pc), .d_reg_write(d_reg_write),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_branch(d_branch)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] ins, input logic [15:0] pc, input logic v);
        instruction = ins;
        Next_PC = pc;
        instr_valid = v;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        drive(16'h0000, 16'h0000, 1'b0);
        tick(); tick();
        checks++; if (d_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", d_valid); end
        checks++; if (d_pc !== 16'h0) begin errors++; $display("[TB] FAIL reset_pc got %h exp 0000", d_pc); end
        checks++; if (d_reg_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_regwrite got %b exp 0", d_reg_write); end
        rst = 1'b0;
        wb_en = 1'b1; wb_addr = 4'd1; wb_data = 16'd5; tick();
        wb_addr = 4'd2; wb_data = 16'd7; tick();
        wb_en = 1'b0;
    endtask

    task automatic test_add();
        drive(16'h0312, 16'h0011, 1'b1);
        tick();
        checks++; if (d_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_valid got %b exp 1", d_valid); end
        checks++; if (d_rs_val !== 16'd5) begin errors++; $display("[TB] FAIL add_rs got %h exp 0005", d_rs_val); end
        checks++; if (d_rt_val !== 16'd7) begin errors++; $display("[TB] FAIL add_rt got %h exp 0007", d_rt_val); end
        checks++; if (d_rd !== 4'd3) begin errors++; $display("[TB] FAIL add_rd got %h exp 3", d_rd); end
        checks++; if (d_reg_write !== 1'b1) begin errors++; $display("[TB] FAIL add_regwrite got %b exp 1", d_reg_write); end
        checks++; if (d_pc !== 16'h0011) begin errors++; $display("[TB] FAIL add_pc got %h exp 0011", d_pc); end
        checks++; if (d_imm !== 16'h0) begin errors++; $display("[TB] FAIL add_imm got %h exp 0000", d_imm); end
    endtask

    task automatic test_load_use();
        drive(16'h5412, 16'h0020, 1'b1);
        tick();
        checks++; if (d_mem_read !== 1'b1) begin errors++; $display("[TB] FAIL lw_memread got %b exp 1", d_mem_read); end
        checks++; if (d_imm !== 16'h0002) begin errors++; $display("[TB] FAIL lw_imm got %h exp 0002", d_imm); end
        checks++; if (d_rs_val !== 16'd5) begin errors++; $display("[TB] FAIL lw_rs got %h exp 0005", d_rs_val); end
        drive(16'h0542, 16'h0021, 1'b1);
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL hazard_stall got %b exp 1", stall); end
        tick();
        checks++; if (d_valid !== 1'b0) begin errors++; $display("[TB] FAIL hazard_bubble got %b exp 0", d_valid); end
        checks++; if (d_mem_read !== 1'b0) begin errors++; $display("[TB] FAIL hazard_ctrl got %b exp 0", d_mem_read); end
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL hazard_oneshot got %b exp 0", stall); end
        tick();
        checks++; if (d_valid !== 1'b1 || d_rd !== 4'd5) begin errors++; $display("[TB] FAIL hazard_retry got v=%b rd=%h exp v=1 rd=5", d_valid, d_rd); end
        checks++; if (d_rt_val !== 16'd7) begin errors++; $display("[TB] FAIL hazard_retry_rt got %h exp 0007", d_rt_val); end
    endtask

    task automatic test_jump();
        drive(16'h8ABC, 16'h1003, 1'b1);
        checks++; if (jump_taken !== 1'b1) begin errors++; $display("[TB] FAIL jmp_taken got %b exp 1", jump_taken); end
        checks++; if (jump_target !== 16'h1ABC) begin errors++; $display("[TB] FAIL jmp_target got %h exp 1abc", jump_target); end
        tick();
        checks++; if (d_valid !== 1'b0) begin errors++; $display("[TB] FAIL jmp_bubble got %b exp 0", d_valid); end
        drive(16'h0312, 16'h1ABD, 1'b1);
        tick();
        checks++; if (d_valid !== 1'b0) begin errors++; $display("[TB] FAIL jmp_squash got %b exp 0", d_valid); end
        tick();
        checks++; if (d_valid !== 1'b1) begin errors++; $display("[TB] FAIL jmp_resume got %b exp 1", d_valid); end
    endtask

    task automatic test_flush();
        drive(16'h5410, 16'h0030, 1'b1);
        tick();
        flush = 1'b1;
        drive(16'h0542, 16'h0031, 1'b1);
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_stall got %b exp 0", stall); end
        tick();
        checks++; if (d_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %b exp 0", d_valid); end
        flush = 1'b0;
        tick();
        checks++; if (d_valid !== 1'b1 || d_rd !== 4'd5) begin errors++; $display("[TB] FAIL flush_after got v=%b rd=%h exp v=1 rd=5", d_valid, d_rd); end
        flush = 1'b1;
        drive(16'h8123, 16'h0040, 1'b1);
        checks++; if (jump_taken !== 1'b0) begin errors++; $display("[TB] FAIL flush_jmp got %b exp 0", jump_taken); end
        tick();
        flush = 1'b0;
        drive(16'h0312, 16'h0041, 1'b1);
        tick();
        checks++; if (d_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_nosquash got %b exp 1", d_valid); end
    endtask

    task automatic test_bypass();
        wb_en = 1'b1; wb_addr = 4'd2; wb_data = 16'h00FF;
        drive(16'h0122, 16'h0050, 1'b1);
        tick();
        checks++; if (d_rs_val !== 16'h00FF || d_rt_val !== 16'h00FF) begin errors++; $display("[TB] FAIL bypass got rs=%h rt=%h exp 00ff", d_rs_val, d_rt_val); end
        wb_addr = 4'd0; wb_data = 16'h1234;
        drive(16'h0100, 16'h0051, 1'b1);
        tick();
        checks++; if (d_rs_val !== 16'h0 || d_rt_val !== 16'h0) begin errors++; $display("[TB] FAIL r0_bypass got rs=%h rt=%h exp 0000", d_rs_val, d_rt_val); end
        wb_en = 1'b0;
        tick();
        checks++; if (d_rs_val !== 16'h0) begin errors++; $display("[TB] FAIL r0_write got %h exp 0000", d_rs_val); end
    endtask

    task automatic test_immediates();
        drive(16'h46F0, 16'h0060, 1'b1);
        tick();
        checks++; if (d_imm !== 16'hFFF0) begin errors++; $display("[TB] FAIL addi_imm got %h exp fff0", d_imm); end
        checks++; if (d_reg_write !== 1'b1 || d_rd !== 4'd6) begin errors++; $display("[TB] FAIL addi_ctrl got w=%b rd=%h exp w=1 rd=6", d_reg_write, d_rd); end
        drive(16'h7128, 16'h0061, 1'b1);
        tick();
        checks++; if (d_imm !== 16'hFFF8) begin errors++; $display("[TB] FAIL beq_imm got %h exp fff8", d_imm); end
        checks++; if (d_branch !== 1'b1 || d_reg_write !== 1'b0) begin errors++; $display("[TB] FAIL beq_ctrl got b=%b w=%b exp b=1 w=0", d_branch, d_reg_write); end
        checks++; if (d_rs_val !== 16'h00FF || d_rt_val !== 16'h0005) begin errors++; $display("[TB] FAIL beq_ops got rs=%h rt=%h exp 00ff/0005", d_rs_val, d_rt_val); end
        drive(16'h6125, 16'h0062, 1'b1);
        tick();
        checks++; if (d_mem_write !== 1'b1 || d_imm !== 16'h0005 || d_rt_val !== 16'h0005) begin errors++; $display("[TB] FAIL sw got mw=%b imm=%h rt=%h exp 1/0005/0005", d_mem_write, d_imm, d_rt_val); end
        drive(16'h9123, 16'h0063, 1'b1);
        tick();
        checks++; if (d_valid !== 1'b1 || d_opcode !== 4'h9 || d_reg_write !== 1'b0 || d_mem_write !== 1'b0) begin errors++; $display("[TB] FAIL undef got v=%b op=%h w=%b mw=%b exp 1/9/0/0", d_valid, d_opcode, d_reg_write, d_mem_write); end
        drive(16'h0312, 16'h0064, 1'b0);
        tick();
        checks++; if (d_valid !== 1'b0) begin errors++; $display("[TB] FAIL invalid_in got %b exp 0", d_valid); end
    endtask

    task automatic test_reset_mid_stall();
        drive(16'h5412, 16'h0070, 1'b1);
        tick();
        drive(16'h0542, 16'h0071, 1'b1);
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL rststall_stall got %b exp 1", stall); end
        rst = 1'b1;
        tick();
        checks++; if (d_valid !== 1'b0 || d_mem_read !== 1'b0) begin errors++; $display("[TB] FAIL rststall_clear got v=%b mr=%b exp 0/0", d_valid, d_mem_read); end
        rst = 1'b0;
        drive(16'h0312, 16'h0072, 1'b1);
        tick();
        checks++; if (d_valid !== 1'b1 || d_rs_val !== 16'h0 || d_rt_val !== 16'h0) begin errors++; $display("[TB] FAIL rststall_regs got v=%b rs=%h rt=%h exp 1/0000/0000", d_valid, d_rs_val, d_rt_val); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_use();
        test_jump();
        test_flush();
        test_bypass();
        test_immediates();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second pipeline stage of the 16-bit core; consumes the fetch latch outputs (instruction, Next_PC) and produces the decode/execute latch.
- Splits instruction fields, reads the register file, sign-extends immediates, and detects load-use hazards (stalls fetch).
- Resolves JMP in place; squashes on execute-stage flush.

Parameters:
- DATA_W, 16, datapath/instruction width
- REG_AW, 4, register address width (16 registers, r0 reads as zero)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- instruction  in  16  instruction from fetch latch
- Next_PC  in  16  PC+1 of that instruction, from fetch latch
- instr_valid  in  1  fetch latch contents valid
- flush  in  1  execute-stage branch taken; kill decode latch and current input
- wb_en  in  1  writeback enable
- wb_addr  in  4  writeback register
- wb_data  in  16  writeback value
- stall  out  1  hold PC and fetch latch this cycle (combinational)
- jump_taken  out  1  JMP decoded this cycle (combinational)
- jump_target  out  16  {Next_PC[15:12], instruction[11:0]}
- d_valid  out  1  decode latch holds a live instruction
- d_opcode  out  4  latched opcode
- d_rd  out  4  latched destination
- d_rs_val, d_rt_val  out  16 each  latched operand values
- d_imm  out  16  latched sign-extended immediate
- d_pc  out  16  latched Next_PC
- d_reg_write, d_mem_read, d_mem_write, d_branch  out  1 each  latched control

Behaviour:
- Fields: op=[15:12], rd=[11:8], rs=[7:4], rt=[3:0]. Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR (R-type, rd<=rs op rt); 4 ADDI (rd<=rd+sext(imm8 [7:0]), sources rd); 5 LW (rd<=M[rs+sext(rt)]); 6 SW (M[rs+sext(rt)]<=rd); 7 BEQ (if rd==rs, PC<=Next_PC+sext(rt)); 8 JMP; 15 NOP. Undefined opcodes decode as NOP (all controls 0, d_valid still 1).
- Register file: 2 async read ports, 1 sync write port. r0 writes ignored, reads return 0. Write-through bypass: if wb_en && wb_addr==read addr && addr!=0, the read returns wb_data in the same cycle.
- Operand sources: R-type use rs,rt; ADDI uses rd; LW uses rs; SW and BEQ use rs,rd. d_rs_val gets the first source, d_rt_val the second (SW/BEQ put rd value in d_rt_val).
- Immediates: ADDI sext 8-bit; LW/SW/BEQ sext 4-bit; else 0.
- Load-use hazard: d_valid && d_mem_read && d_rd!=0 && d_rd matches any source of a valid input -> stall=1 and latch a bubble (d_valid<=0, controls 0). Input is held by fetch and re-decoded next cycle. Hazard lasts exactly one cycle.
- JMP: jump_taken=1 when valid JMP && !stall && !flush. The latch takes a bubble. An internal squash flag is set, so the next cycle's input is treated as invalid. Squash clears after one cycle.
- Priority, highest first: rst > flush > stall > squash > normal.
- flush: d_valid<=0, squash cleared, stall and jump_taken forced 0.
- Latency: one cycle, input to d_* outputs.
- Reset: all d_* outputs 0, squash 0, register file contents 0. Reset mid-stall drops the pending instruction.

Decomposition:
- Shared package: opcode constants (OP_ADD..OP_NOP), field bit positions, DATA_W/REG_AW.
- One sub-module: register_file (16x16, 2R1W, r0 zero, write bypass).

Test Plan:
- Reset, then ADD r3,r1,r2 with r1=5, r2=7 preloaded via wb -> next cycle d_valid=1, d_rs_val=5, d_rt_val=7, d_rd=3, d_reg_write=1.
- LW r4,r1,2 followed by ADD r5,r4,r2 -> cycle 2: stall=1, d_valid=0; cycle 3: ADD latched, stall=0.
- JMP 0x0ABC with Next_PC=0x1003 -> jump_taken=1, jump_target=0x1ABC; following input squashed (d_valid=0 two cycles).
- Writeback r2=0x00FF while decoding ADD r1,r2,r2 -> d_rs_val=d_rt_val=0x00FF (bypass). wb to r0 -> r0 still reads 0.
- flush asserted during load-use stall -> stall=0, d_valid=0 next cycle.
- ADDI r6,0xF0 -> d_imm=0xFFF0; BEQ offset 0x8 -> d_imm=0xFFF8, d_branch=1.
